id_ex_stage: RTL and testbench

- Pipeline register between instruction decode and execute for the 16-bit RISC-V-style core.
- Captures the decoder's control bundle (ALU source, ALU op, branch, memory write, memory-to-register, register write) together with operand data, immediate and register addresses, and presents them to the EX stage.
- Contains the load-use hazard detector: requests an IF/ID stall and injects a bubble.
- Also supports branch flush and downstream hold, and keeps a saturating bubble counter.

---
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit core, with load-use hazard detection,
// branch flush, downstream hold and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_alu_src,
  input  logic                  id_branch,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_alu_op,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic [1:0]            ex_alu_op,
  output logic [DATA_W-1:0]     ex_rs1_data,
  output logic [DATA_W-1:0]     ex_rs2_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [CNT_W-1:0]      bubble_count
);

  logic                  valid_q, valid_d;
  logic                  alu_src_q, alu_src_d, branch_q, branch_d;
  logic                  mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic                  reg_write_q, reg_write_d;
  logic [1:0]            alu_op_q, alu_op_d;
  logic [DATA_W-1:0]     rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  uses_rs2, load_use, bubble;

  // R-type, stores and branches all read rs2; I-type ALU ops and loads do not.
  assign uses_rs2 = !id_alu_src | id_mem_write | id_branch;
  assign load_use = valid_q & mem_to_reg_q & (rd_q != '0) & id_valid &
                    ((rd_q == id_rs1) | (uses_rs2 & (rd_q == id_rs2)));
  assign hazard_stall = load_use & !flush & !ex_hold;
  // Flush outranks hold; a load-use bubble only goes in when not held.
  assign bubble = flush | (!ex_hold & load_use);

  always_comb begin
    valid_d      = valid_q;
    alu_src_d    = alu_src_q;
    branch_d     = branch_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    alu_op_d     = alu_op_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    if (bubble) begin
      valid_d      = 1'b0;
      alu_src_d    = 1'b0;
      branch_d     = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      alu_op_d     = '0;
      rs1_data_d   = '0;
      rs2_data_d   = '0;
      imm_d        = '0;
      rs1_d        = '0;
      rs2_d        = '0;
      rd_d         = '0;
    end else if (!ex_hold) begin
      valid_d      = id_valid;
      alu_src_d    = id_alu_src & id_valid;
      branch_d     = id_branch & id_valid;
      mem_write_d  = id_mem_write & id_valid;
      mem_to_reg_d = id_mem_to_reg & id_valid;
      reg_write_d  = id_reg_write & id_valid;
      alu_op_d     = id_alu_op & {2{id_valid}};
      rs1_data_d   = id_rs1_data;
      rs2_data_d   = id_rs2_data;
      imm_d        = id_imm;
      rs1_d        = id_rs1;
      rs2_d        = id_rs2;
      rd_d         = id_rd;
    end
    if (hazard_stall && (cnt_q != '1))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      alu_src_q    <= 1'b0;
      branch_q     <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_op_q     <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      alu_src_q    <= alu_src_d;
      branch_q     <= branch_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      alu_op_q     <= alu_op_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_branch     = branch_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage: a behavioural EX-register model checked every
// cycle, plus directed sequences with literal expectations.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 0, id_alu_src = 0, id_branch = 0, id_mem_write = 0;
  logic id_mem_to_reg = 0, id_reg_write = 0;
  logic [1:0] id_alu_op = 0;
  logic [15:0] id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
  logic [2:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic flush = 0, ex_hold = 0;

  logic hazard_stall, ex_valid, ex_alu_src, ex_branch, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [1:0] ex_alu_op;
  logic [15:0] ex_rs1_data, ex_rs2_data, ex_imm, bubble_count;
  logic [2:0] ex_rs1, ex_rs2, ex_rd;

  logic s_hazard_stall, s_ex_valid, s_ex_alu_src, s_ex_branch, s_ex_mem_write, s_ex_mem_to_reg, s_ex_reg_write;
  logic [1:0] s_ex_alu_op;
  logic [15:0] s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [2:0] s_ex_rs1, s_ex_rs2, s_ex_rd, s_bubble_count;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .flush(flush), .ex_hold(ex_hold), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_alu_op(ex_alu_op), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .bubble_count(bubble_count)
  );

  // Narrow-counter instance on the same inputs so saturation is reachable quickly.
  id_ex_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .flush(flush), .ex_hold(ex_hold), .hazard_stall(s_hazard_stall),
    .ex_valid(s_ex_valid), .ex_alu_src(s_ex_alu_src), .ex_branch(s_ex_branch),
    .ex_mem_write(s_ex_mem_write), .ex_mem_to_reg(s_ex_mem_to_reg), .ex_reg_write(s_ex_reg_write),
    .ex_alu_op(s_ex_alu_op), .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data),
    .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
    .bubble_count(s_bubble_count)
  );

  typedef struct packed {
    logic v, alu_src, branch, mem_write, mem_to_reg, reg_write;
    logic [1:0] alu_op;
    logic [15:0] rs1d, rs2d, imm;
    logic [2:0] rs1, rs2, rd;
  } ex_t;

  ex_t m = '0;
  int unsigned mcnt = 0, mcnt_s = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_load_use();
    bit reads_rs2 = !id_alu_src || id_mem_write || id_branch;
    return m.v && m.mem_to_reg && (m.rd != 0) && id_valid &&
           ((m.rd == id_rs1) || (reads_rs2 && (m.rd == id_rs2)));
  endfunction

  // Reference: priority flush > hold > load-use bubble > capture.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '0; mcnt = 0; mcnt_s = 0;
    end else if (flush) begin
      m = '0;
    end else if (ex_hold) begin
      m = m;
    end else if (m_load_use()) begin
      m = '0;
      if (mcnt < 65535) mcnt++;
      if (mcnt_s < 7) mcnt_s++;
    end else begin
      m.v = id_valid;
      m.alu_src = id_valid && id_alu_src;
      m.branch = id_valid && id_branch;
      m.mem_write = id_valid && id_mem_write;
      m.mem_to_reg = id_valid && id_mem_to_reg;
      m.reg_write = id_valid && id_reg_write;
      m.alu_op = id_valid ? id_alu_op : 2'b00;
      m.rs1d = id_rs1_data; m.rs2d = id_rs2_data; m.imm = id_imm;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
    end
  end

  ex_t dut_bundle;
  assign dut_bundle = '{ex_valid, ex_alu_src, ex_branch, ex_mem_write, ex_mem_to_reg,
                        ex_reg_write, ex_alu_op, ex_rs1_data, ex_rs2_data, ex_imm,
                        ex_rs1, ex_rs2, ex_rd};

  always @(negedge clk) begin
    chk("ex_bundle", 65'(dut_bundle), 65'(m));
    chk("bubble_count", 65'(bubble_count), 65'(mcnt));
    chk("bubble_count_sat3", 65'(s_bubble_count), 65'(mcnt_s));
    chk("hazard_stall", 65'(hazard_stall), 65'(m_load_use() && !flush && !ex_hold));
    if (!ex_valid)
      chk("bubble_invariant", 65'({ex_reg_write, ex_mem_write, ex_branch, ex_mem_to_reg}), 65'(0));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic v, input logic asrc, input logic [1:0] op, input logic br,
                        input logic mw, input logic m2r, input logic rw, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] im, input logic [2:0] r1,
                        input logic [2:0] r2, input logic [2:0] rd);
    id_valid = v; id_alu_src = asrc; id_alu_op = op; id_branch = br; id_mem_write = mw;
    id_mem_to_reg = m2r; id_reg_write = rw; id_rs1_data = d1; id_rs2_data = d2; id_imm = im;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
  endtask

  task automatic set_load(input logic [2:0] rd);
    set_id(1, 1, 2'b00, 0, 0, 1, 1, 16'h0100, 16'h0, 16'h0004, 3'd1, 3'd0, rd);
  endtask

  task automatic set_rand();
    set_id($urandom_range(0, 99) < 85, 1'($urandom), 2'($urandom), $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3, 1'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           3'($urandom_range(0, 3)));
  endtask

  initial begin
    // Reset while ID carries nonzero values.
    set_id(1, 1, 2'b11, 1, 1, 1, 1, 16'hBEEF, 16'hCAFE, 16'h7777, 3'd5, 3'd6, 3'd7);
    repeat (3) tick();
    chk("reset_bundle", 65'(dut_bundle), 65'(0));
    chk("reset_count", 65'(bubble_count), 65'(0));
    chk("reset_stall", 65'(hazard_stall), 65'(0));
    rst_n = 1'b1;

    // R-type pass-through.
    set_id(1, 0, 2'b10, 0, 0, 0, 1, 16'h1234, 16'h00FF, 16'h0000, 3'd1, 3'd2, 3'd3);
    tick();
    chk("rtype_rs1_data", 65'(ex_rs1_data), 65'(16'h1234));
    chk("rtype_rs2_data", 65'(ex_rs2_data), 65'(16'h00FF));
    chk("rtype_ctl", 65'({ex_valid, ex_alu_op, ex_reg_write, ex_rd}), 65'({1'b1, 2'b10, 1'b1, 3'd3}));

    // Load rd=2 then R-type reading rs2=2: one bubble.
    set_load(3'd2); tick();
    set_id(1, 0, 2'b10, 0, 0, 0, 1, 16'h1111, 16'h2222, 16'h0, 3'd5, 3'd2, 3'd6); #1;
    chk("lu_stall", 65'(hazard_stall), 65'(1));
    tick();
    chk("lu_bubble", 65'({ex_valid, ex_reg_write, ex_mem_to_reg}), 65'(0));
    chk("lu_count", 65'(bubble_count), 65'(1));
    chk("lu_stall_clears", 65'(hazard_stall), 65'(0));
    tick();
    chk("lu_replay", 65'({ex_valid, ex_rd, ex_rs1_data}), 65'({1'b1, 3'd6, 16'h1111}));

    // No stall on rd=0, nor on an I-type whose unused rs2 matches.
    set_load(3'd0); tick();
    set_id(1, 0, 2'b10, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd1); #1;
    chk("rd0_no_stall", 65'(hazard_stall), 65'(0));
    tick();
    set_load(3'd4); tick();
    set_id(1, 1, 2'b00, 0, 0, 0, 1, 16'h5, 16'h6, 16'h7, 3'd1, 3'd4, 3'd2); #1;
    chk("itype_no_stall", 65'(hazard_stall), 65'(0));
    tick();

    // Flush with hold: bubble, no stall, count untouched.
    set_load(3'd3); tick();
    set_id(1, 0, 2'b10, 0, 0, 0, 1, 16'h9, 16'h9, 16'h0, 3'd3, 3'd1, 3'd5);
    flush = 1; ex_hold = 1; #1;
    chk("flush_no_stall", 65'(hazard_stall), 65'(0));
    tick();
    chk("flush_bubble", 65'({ex_valid, ex_mem_to_reg, ex_rd}), 65'(0));
    chk("flush_count", 65'(bubble_count), 65'(1));
    flush = 0; ex_hold = 0;

    // Hold freezes EX for three cycles.
    set_id(1, 0, 2'b01, 0, 0, 0, 1, 16'hAAAA, 16'h5555, 16'h0, 3'd1, 3'd2, 3'd5); tick();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_rand(); tick();
      chk("hold_frozen", 65'({ex_valid, ex_rs1_data, ex_rs2_data, ex_rd}),
          65'({1'b1, 16'hAAAA, 16'h5555, 3'd5}));
    end
    ex_hold = 0;

    // Nine more hazards: 3-bit counter must stick at 7.
    for (int i = 0; i < 9; i++) begin
      set_load(3'd2); tick();
      set_id(1, 0, 2'b10, 0, 0, 0, 1, 16'h3, 16'h4, 16'h0, 3'd2, 3'd1, 3'd6);
      tick(); tick();
    end
    chk("count_after_9", 65'(bubble_count), 65'(10));
    chk("count_sat3", 65'(s_bubble_count), 65'(7));

    // Random traffic; upstream re-presents the instruction while stalled or held.
    for (int i = 0; i < 3000; i++) begin
      flush = $urandom_range(0, 99) < 5;
      ex_hold = $urandom_range(0, 99) < 10;
      if (!(m_load_use() || ex_hold) || $urandom_range(0, 9) == 0) set_rand();
      if (i == 1500 || i == 2400) begin
        #3 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_count", 65'(bubble_count), 65'(0));
        chk("midreset_valid", 65'(ex_valid), 65'(0));
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
